// File: rtl/xgmii_pkg.sv
// XGMII character constants and loopback-channel mode encoding shared by the
// loopback channel and its delay line.
package xgmii_pkg;

  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_ERROR = 8'hFE;

  // Local-fault ordered set, repeated in both 32-bit columns of a 64-bit word.
  localparam logic [63:0] XGMII_LF_DATA = 64'h0100009C_0100009C;
  localparam logic [7:0]  XGMII_LF_CTRL = 8'h11;

  typedef enum logic [1:0] {
    PASS    = 2'd0,
    DELAY   = 2'd1,
    CORRUPT = 2'd2,
    FAULT   = 2'd3
  } loop_mode_e;

endpackage

// File: rtl/xgmii_delay_line.sv
// Circular XGMII word buffer: written every cycle, read `offset` words behind
// the write pointer; reset and flush refill every entry with Idle.
module xgmii_delay_line
  import xgmii_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int DELAY_MAX = 16,
  parameter int OFF_W     = $clog2(DELAY_MAX + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_ctrl,
  input  logic [OFF_W-1:0]      offset,
  output logic [DATA_W-1:0]     rd_data,
  output logic [DATA_W/8-1:0]   rd_ctrl
);

  localparam int LANES = DATA_W / 8;
  localparam int AW    = (DELAY_MAX > 1) ? $clog2(DELAY_MAX) : 1;
  localparam int DEPTH = 1 << AW;

  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [LANES-1:0]  mem_c [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_idx;
  logic [OFF_W-1:0]  wr_ext;

  assign wr_ext = OFF_W'(wr_ptr);

  // Pointer wraps at DELAY_MAX, not at the power-of-two storage depth.
  always_comb begin
    if (wr_ext >= offset) rd_idx = AW'(wr_ext - offset);
    else                  rd_idx = AW'(wr_ext + OFF_W'(DELAY_MAX) - offset);
  end

  assign rd_data = mem_d[rd_idx];
  assign rd_ctrl = mem_c[rd_idx];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i] <= {LANES{XGMII_IDLE}};
        mem_c[i] <= '1;
      end
    end else begin
      mem_d[wr_ptr] <= wr_data;
      mem_c[wr_ptr] <= wr_ctrl;
    end

    if (reset)                                wr_ptr <= '0;
    else if (wr_ptr == AW'(DELAY_MAX - 1))    wr_ptr <= '0;
    else                                      wr_ptr <= wr_ptr + AW'(1);
  end

endmodule

// File: rtl/xgmii_loopback_chan.sv
// XGMII loopback channel between MAC tx and rx with programmable latency,
// periodic start-word corruption and forced local fault.
module xgmii_loopback_chan
  import xgmii_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int DELAY_MAX = 16,
  parameter int DLY_W     = $clog2(DELAY_MAX + 1)
) (
  input  logic                clk_156m25,
  input  logic                reset_156m25,
  input  logic [DATA_W-1:0]   xgmii_txd,
  input  logic [DATA_W/8-1:0] xgmii_txc,
  input  logic [1:0]          cfg_mode,
  input  logic [DLY_W-1:0]    cfg_delay,
  input  logic [7:0]          cfg_err_every,
  output logic [DATA_W-1:0]   xgmii_rxd,
  output logic [DATA_W/8-1:0] xgmii_rxc,
  output logic [1:0]          mode_active,
  output logic                busy,
  output logic [31:0]         frame_cnt,
  output logic [15:0]         err_inj_cnt
);

  localparam int LANES = DATA_W / 8;
  localparam logic [DATA_W-1:0] IDLE_D = {LANES{XGMII_IDLE}};
  localparam logic [DATA_W-1:0] LF_D   = {(DATA_W / 64){XGMII_LF_DATA}};
  localparam logic [LANES-1:0]  LF_C   = {(DATA_W / 64){XGMII_LF_CTRL}};

  loop_mode_e        mode_q, mode_req;
  logic [DLY_W-1:0]  dly_q, dly_req;
  logic [DLY_W-1:0]  inflight;
  logic [7:0]        mod_cnt, mod_next;
  logic              in_frame;
  logic              is_start, is_term, tx_idle, boundary, inject, flush;
  logic              wr_live, rd_live;
  logic [DATA_W-1:0] w_d, buf_d;
  logic [LANES-1:0]  w_c, buf_c;

  always_comb begin
    is_start = xgmii_txc[0] && (xgmii_txd[7:0] == XGMII_START);
    is_term  = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (xgmii_txc[i] && (xgmii_txd[8*i +: 8] == XGMII_TERM)) is_term = 1'b1;
    end
  end

  assign tx_idle  = (xgmii_txc == '1) && (xgmii_txd == IDLE_D);
  assign boundary = tx_idle && !in_frame && (inflight == '0);
  assign mode_req = loop_mode_e'(cfg_mode);
  assign dly_req  = (mode_req == PASS) ? '0 :
                    (cfg_delay > DLY_W'(DELAY_MAX)) ? DLY_W'(DELAY_MAX) : cfg_delay;
  assign mod_next = mod_cnt + 8'd1;
  assign inject   = (mode_q == CORRUPT) && is_start && (cfg_err_every != 8'd0) &&
                    (mod_next == cfg_err_every);

  // Word entering the channel after fault masking and error injection.
  always_comb begin
    w_d = xgmii_txd;
    w_c = xgmii_txc;
    if (mode_q == FAULT) begin
      w_d = IDLE_D;
      w_c = '1;
    end else if (inject) begin
      w_d[DATA_W-1 -: 8] = XGMII_ERROR;
      w_c[LANES-1]       = 1'b1;
    end
  end

  // Any delay change or fault exit empties the buffer; at a boundary it only holds Idle.
  assign flush   = boundary && ((dly_req != dly_q) || ((mode_q == FAULT) && (mode_req != FAULT)));
  assign wr_live = (dly_q != '0) && !((w_c == '1) && (w_d == IDLE_D));
  assign rd_live = (dly_q != '0) && !((buf_c == '1) && (buf_d == IDLE_D));

  xgmii_delay_line #(
    .DATA_W    (DATA_W),
    .DELAY_MAX (DELAY_MAX),
    .OFF_W     (DLY_W)
  ) u_delay_line (
    .clk     (clk_156m25),
    .reset   (reset_156m25),
    .flush   (flush),
    .wr_data (w_d),
    .wr_ctrl (w_c),
    .offset  (dly_q),
    .rd_data (buf_d),
    .rd_ctrl (buf_c)
  );

  always_ff @(posedge clk_156m25) begin
    if (reset_156m25) begin
      mode_q      <= PASS;
      dly_q       <= '0;
      in_frame    <= 1'b0;
      inflight    <= '0;
      mod_cnt     <= '0;
      frame_cnt   <= '0;
      err_inj_cnt <= '0;
      xgmii_rxd   <= IDLE_D;
      xgmii_rxc   <= '1;
    end else begin
      if (is_start)     in_frame <= 1'b1;
      else if (is_term) in_frame <= 1'b0;

      if (flush)                    inflight <= '0;
      else if (wr_live && !rd_live) inflight <= inflight + DLY_W'(1);
      else if (!wr_live && rd_live) inflight <= inflight - DLY_W'(1);

      if (mode_q == FAULT) begin
        xgmii_rxd <= LF_D;
        xgmii_rxc <= LF_C;
      end else if (dly_q == '0) begin
        xgmii_rxd <= w_d;
        xgmii_rxc <= w_c;
      end else begin
        xgmii_rxd <= buf_d;
        xgmii_rxc <= buf_c;
      end

      if (is_start && (mode_q != FAULT)) frame_cnt <= frame_cnt + 32'd1;

      if (inject) begin
        mod_cnt <= '0;
        if (err_inj_cnt != 16'hFFFF) err_inj_cnt <= err_inj_cnt + 16'd1;
      end else if ((mode_q == CORRUPT) && is_start) begin
        mod_cnt <= mod_next;
      end

      if (boundary) begin
        if ((mode_req == CORRUPT) && (mode_q != CORRUPT)) mod_cnt <= '0;
        mode_q <= mode_req;
        dly_q  <= dly_req;
      end
    end
  end

  assign mode_active = mode_q;
  assign busy        = in_frame || (inflight != '0);

endmodule

// File: tb/tb_xgmii_loopback_chan.sv
// Directed bench for xgmii_loopback_chan: reset, PASS latency, DELAY with
// clamping, CORRUPT cadence, deferred mode change and FAULT exit.
module tb_xgmii_loopback_chan;

  localparam logic [63:0] IDLE_D  = 64'h0707070707070707;
  localparam logic [7:0]  IDLE_C  = 8'hFF;
  localparam logic [63:0] LF_D    = 64'h0100009C0100009C;
  localparam logic [7:0]  LF_C    = 8'h11;
  localparam logic [63:0] START_D = 64'hD5555555555555FB;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] txd;
  logic [7:0]  txc;
  logic [1:0]  cfg_mode;
  logic [4:0]  cfg_delay;
  logic [7:0]  cfg_err_every;
  logic [63:0] rxd;
  logic [7:0]  rxc;
  logic [1:0]  mode_active;
  logic        busy;
  logic [31:0] frame_cnt;
  logic [15:0] err_inj_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus, expected (post-injection) words and captured outputs per step.
  logic [63:0] sd[$], ed[$], gd[$];
  logic [7:0]  sc[$], ec[$], gc[$];
  logic [1:0]  gm[$];

  xgmii_loopback_chan dut (
    .clk_156m25    (clk),
    .reset_156m25  (rst),
    .xgmii_txd     (txd),
    .xgmii_txc     (txc),
    .cfg_mode      (cfg_mode),
    .cfg_delay     (cfg_delay),
    .cfg_err_every (cfg_err_every),
    .xgmii_rxd     (rxd),
    .xgmii_rxc     (rxc),
    .mode_active   (mode_active),
    .busy          (busy),
    .frame_cnt     (frame_cnt),
    .err_inj_cnt   (err_inj_cnt)
  );

  always #5 clk = ~clk;

  task automatic clear_q();
    sd.delete(); sc.delete(); ed.delete(); ec.delete();
  endtask

  task automatic push_word(input logic [63:0] d, input logic [7:0] c);
    sd.push_back(d); sc.push_back(c);
    ed.push_back(d); ec.push_back(c);
  endtask

  task automatic push_idle(input int n);
    repeat (n) push_word(IDLE_D, IDLE_C);
  endtask

  // Start word, 8 data words (64 bytes), Terminate on lane 4.
  task automatic push_frame(input int f, input bit corrupt);
    logic [63:0] d;
    d = START_D;
    sd.push_back(d); sc.push_back(8'h01);
    if (corrupt) begin
      ed.push_back({8'hFE, d[55:0]}); ec.push_back(8'h81);
    end else begin
      ed.push_back(d); ec.push_back(8'h01);
    end
    for (int i = 0; i < 8; i++) push_word({4{f[7:0], 8'(i)}}, 8'h00);
    push_word({24'h070707, 8'hFD, f[7:0], 24'hA0B1C2}, 8'hF0);
  endtask

  // Drives the stimulus queue one word per cycle; optionally changes cfg_mode
  // just before step cfg_at.
  task automatic run_stim(input int cfg_at, input logic [1:0] new_mode);
    gd.delete(); gc.delete(); gm.delete();
    for (int i = 0; i < sd.size(); i++) begin
      if (i == cfg_at) cfg_mode = new_mode;
      txd = sd[i];
      txc = sc[i];
      @(posedge clk); #1;
      gd.push_back(rxd); gc.push_back(rxc); gm.push_back(mode_active);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cfg_mode = 2'd0; cfg_delay = 5'd0; cfg_err_every = 8'd0;
    txd = START_D; txc = 8'h01;
    @(posedge clk); #1;
    txd = 64'h1122334455667788; txc = 8'h00;
    @(posedge clk); #1;
    txd = 64'h07070707070707FD; txc = 8'hFF;
    @(posedge clk); #1;
    n_checks++; if (rxd !== IDLE_D) begin n_fail++; $display("FAIL reset_rxd: got %h want %h", rxd, IDLE_D); end
    n_checks++; if (rxc !== IDLE_C) begin n_fail++; $display("FAIL reset_rxc: got %h want %h", rxc, IDLE_C); end
    n_checks++; if (frame_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); end
    n_checks++; if (err_inj_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d want 0", err_inj_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (mode_active !== 2'd0) begin n_fail++; $display("FAIL reset_mode: got %0d want 0", mode_active); end
    rst = 1'b0;
    txd = IDLE_D; txc = IDLE_C;
    @(posedge clk); #1;
  endtask

  task automatic test_pass();
    cfg_mode = 2'd0; cfg_delay = 5'd0;
    clear_q(); push_idle(2); push_frame(1, 1'b0); push_idle(3);
    run_stim(-1, 2'd0);
    for (int i = 0; i < sd.size(); i++) begin
      n_checks++;
      if (gd[i] !== ed[i] || gc[i] !== ec[i]) begin
        n_fail++; $display("FAIL pass_word[%0d]: got %h/%h want %h/%h", i, gd[i], gc[i], ed[i], ec[i]);
      end
    end
    n_checks++; if (frame_cnt !== 32'd1) begin n_fail++; $display("FAIL pass_frame_cnt: got %0d want 1", frame_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL pass_busy: got %b want 0", busy); end
  endtask

  task automatic test_delay();
    logic [63:0] xd;
    logic [7:0]  xc;
    cfg_mode = 2'd1; cfg_delay = 5'd5;
    clear_q(); push_idle(2); push_frame(2, 1'b0); push_frame(3, 1'b0); push_idle(8);
    run_stim(-1, 2'd1);
    n_checks++; if (gm[1] !== 2'd1) begin n_fail++; $display("FAIL delay_mode: got %0d want 1", gm[1]); end
    for (int i = 0; i < sd.size(); i++) begin
      xd = (i >= 5) ? ed[i-5] : IDLE_D;
      xc = (i >= 5) ? ec[i-5] : IDLE_C;
      n_checks++;
      if (gd[i] !== xd || gc[i] !== xc) begin
        n_fail++; $display("FAIL delay5_word[%0d]: got %h/%h want %h/%h", i, gd[i], gc[i], xd, xc);
      end
    end
    // 31 is the largest value the 5-bit port holds; it clamps to 16.
    cfg_delay = 5'd31;
    clear_q(); push_idle(2); push_frame(4, 1'b0); push_idle(18);
    run_stim(-1, 2'd1);
    for (int i = 0; i < sd.size(); i++) begin
      xd = (i >= 16) ? ed[i-16] : IDLE_D;
      xc = (i >= 16) ? ec[i-16] : IDLE_C;
      n_checks++;
      if (gd[i] !== xd || gc[i] !== xc) begin
        n_fail++; $display("FAIL delay_clamp_word[%0d]: got %h/%h want %h/%h", i, gd[i], gc[i], xd, xc);
      end
    end
    n_checks++; if (frame_cnt !== 32'd4) begin n_fail++; $display("FAIL delay_frame_cnt: got %0d want 4", frame_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL delay_busy: got %b want 0", busy); end
  endtask

  task automatic test_corrupt();
    cfg_mode = 2'd2; cfg_delay = 5'd0; cfg_err_every = 8'd2;
    clear_q(); push_idle(2);
    for (int f = 5; f < 9; f++) begin
      push_frame(f, ((f - 5) % 2) == 1);
      push_idle(2);
    end
    run_stim(-1, 2'd2);
    for (int i = 0; i < sd.size(); i++) begin
      n_checks++;
      if (gd[i] !== ed[i] || gc[i] !== ec[i]) begin
        n_fail++; $display("FAIL corrupt_word[%0d]: got %h/%h want %h/%h", i, gd[i], gc[i], ed[i], ec[i]);
      end
    end
    n_checks++; if (err_inj_cnt !== 16'd2) begin n_fail++; $display("FAIL corrupt_err_cnt: got %0d want 2", err_inj_cnt); end
    n_checks++; if (frame_cnt !== 32'd8) begin n_fail++; $display("FAIL corrupt_frame_cnt: got %0d want 8", frame_cnt); end
  endtask

  task automatic test_deferred();
    logic [63:0] xd;
    logic [7:0]  xc;
    cfg_mode = 2'd0; cfg_delay = 5'd0;
    clear_q(); push_idle(2); push_frame(9, 1'b0); push_idle(4);
    run_stim(6, 2'd3);
    for (int i = 0; i < sd.size(); i++) begin
      xd = (i >= 13) ? LF_D : ed[i];
      xc = (i >= 13) ? LF_C : ec[i];
      n_checks++;
      if (gd[i] !== xd || gc[i] !== xc) begin
        n_fail++; $display("FAIL deferred_word[%0d]: got %h/%h want %h/%h", i, gd[i], gc[i], xd, xc);
      end
    end
    n_checks++; if (gm[6] !== 2'd0) begin n_fail++; $display("FAIL deferred_mode_mid: got %0d want 0", gm[6]); end
    n_checks++; if (gm[11] !== 2'd0) begin n_fail++; $display("FAIL deferred_mode_term: got %0d want 0", gm[11]); end
    n_checks++; if (gm[12] !== 2'd3) begin n_fail++; $display("FAIL deferred_mode_switch: got %0d want 3", gm[12]); end
    n_checks++; if (frame_cnt !== 32'd9) begin n_fail++; $display("FAIL deferred_frame_cnt: got %0d want 9", frame_cnt); end
  endtask

  task automatic test_fault_exit();
    logic [63:0] xd;
    logic [7:0]  xc;
    cfg_mode = 2'd3; cfg_delay = 5'd8;
    clear_q(); push_idle(2); push_frame(20, 1'b0); push_idle(3);
    run_stim(-1, 2'd3);
    for (int i = 0; i < sd.size(); i++) begin
      n_checks++;
      if (gd[i] !== LF_D || gc[i] !== LF_C) begin
        n_fail++; $display("FAIL fault_word[%0d]: got %h/%h want %h/%h", i, gd[i], gc[i], LF_D, LF_C);
      end
    end
    n_checks++; if (frame_cnt !== 32'd9) begin n_fail++; $display("FAIL fault_frame_cnt: got %0d want 9", frame_cnt); end
    cfg_mode = 2'd1; cfg_delay = 5'd2;
    clear_q(); push_idle(4); push_frame(10, 1'b0); push_idle(6);
    run_stim(-1, 2'd1);
    n_checks++; if (gm[0] !== 2'd1) begin n_fail++; $display("FAIL exit_mode: got %0d want 1", gm[0]); end
    for (int i = 0; i < sd.size(); i++) begin
      if (i == 0) begin
        xd = LF_D; xc = LF_C;
      end else begin
        xd = (i >= 2) ? ed[i-2] : IDLE_D;
        xc = (i >= 2) ? ec[i-2] : IDLE_C;
      end
      n_checks++;
      if (gd[i] !== xd || gc[i] !== xc) begin
        n_fail++; $display("FAIL exit_word[%0d]: got %h/%h want %h/%h", i, gd[i], gc[i], xd, xc);
      end
    end
    n_checks++; if (frame_cnt !== 32'd10) begin n_fail++; $display("FAIL exit_frame_cnt: got %0d want 10", frame_cnt); end
    n_checks++; if (err_inj_cnt !== 16'd2) begin n_fail++; $display("FAIL exit_err_cnt: got %0d want 2", err_inj_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL exit_busy: got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_delay();
    test_corrupt();
    test_deferred();
    test_fault_exit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
